// File: rtl/watch_pkg.sv
// Shared constants, field widths and FSM encoding for the watch time-keeping core.
package watch_pkg;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_SEC  = 2'd1,
        SET_MIN  = 2'd2,
        SET_HOUR = 2'd3
    } watch_state_t;

    localparam logic [2:0] POS_NONE = 3'b000;
    localparam logic [2:0] POS_SEC  = 3'b001;
    localparam logic [2:0] POS_MIN  = 3'b010;
    localparam logic [2:0] POS_HOUR = 3'b100;

    function automatic logic [2:0] pos_of(input watch_state_t s);
        case (s)
            SET_SEC:  return POS_SEC;
            SET_MIN:  return POS_MIN;
            SET_HOUR: return POS_HOUR;
            default:  return POS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/watch_tick_gen.sv
// Divides clk down to a one-cycle tick every DIV cycles; held at zero while disabled.
module watch_tick_gen #(
    parameter int DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (cnt == LAST);

endmodule

// File: rtl/watch_time_core.sv
// Watch time source: cascaded centisecond..hour counters with a RUN/SET edit FSM.
//   state    | meaning
//   RUN      | time advances on each tick, buttons except mode ignored
//   SET_SEC  | seconds field selected for up/down edits, time frozen
//   SET_MIN  | minutes field selected
//   SET_HOUR | hours field selected
module watch_time_core
    import watch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100,
    parameter int INIT_HOUR   = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_btn_mode,
    input  logic        i_btn_next,
    input  logic        i_btn_up,
    input  logic        i_btn_down,
    output logic [6:0]  o_msec,
    output logic [5:0]  o_sec,
    output logic [5:0]  o_min,
    output logic [4:0]  o_hour,
    output logic [2:0]  o_pos_sel,
    output logic        o_edit
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

    watch_state_t       state_q, state_n;
    logic [MSEC_W-1:0]  msec_q, msec_n;
    logic [SEC_W-1:0]   sec_q, sec_n;
    logic [MIN_W-1:0]   min_q, min_n;
    logic [HOUR_W-1:0]  hour_q, hour_n;
    logic [2:0]         pos_q;
    logic               edit_q;
    logic               tick;
    logic               run_en;

    assign run_en = (state_q == RUN);

    watch_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   (run_en),
        .o_tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            msec_q  <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= HOUR_W'(INIT_HOUR);
            pos_q   <= POS_NONE;
            edit_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            msec_q  <= msec_n;
            sec_q   <= sec_n;
            min_q   <= min_n;
            hour_q  <= hour_n;
            pos_q   <= pos_of(state_n);
            edit_q  <= (state_n != RUN);
        end
    end

    always_comb begin
        state_n = state_q;
        msec_n  = msec_q;
        sec_n   = sec_q;
        min_n   = min_q;
        hour_n  = hour_q;
        case (state_q)
            RUN: begin
                // mode wins over a coincident tick; msec is zeroed on entry to SET
                if (i_btn_mode) begin
                    state_n = SET_SEC;
                    msec_n  = '0;
                end else if (tick) begin
                    msec_n = (msec_q == MSEC_MAX) ? '0 : msec_q + 7'd1;
                    if (msec_q == MSEC_MAX) begin
                        sec_n = (sec_q == SEC_MAX) ? '0 : sec_q + 6'd1;
                        if (sec_q == SEC_MAX) begin
                            min_n = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;
                            if (min_q == MIN_MAX)
                                hour_n = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
                        end
                    end
                end
            end
            SET_SEC, SET_MIN, SET_HOUR: begin
                if (i_btn_mode) begin
                    state_n = RUN;
                end else if (i_btn_next) begin
                    case (state_q)
                        SET_SEC: state_n = SET_MIN;
                        SET_MIN: state_n = SET_HOUR;
                        default: state_n = SET_SEC;
                    endcase
                end else if (i_btn_up) begin
                    case (state_q)
                        SET_SEC: sec_n  = (sec_q == SEC_MAX)   ? '0 : sec_q + 6'd1;
                        SET_MIN: min_n  = (min_q == MIN_MAX)   ? '0 : min_q + 6'd1;
                        default: hour_n = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
                    endcase
                end else if (i_btn_down) begin
                    case (state_q)
                        SET_SEC: sec_n  = (sec_q == '0)  ? SEC_MAX  : sec_q - 6'd1;
                        SET_MIN: min_n  = (min_q == '0)  ? MIN_MAX  : min_q - 6'd1;
                        default: hour_n = (hour_q == '0) ? HOUR_MAX : hour_q - 5'd1;
                    endcase
                end
            end
            default: state_n = RUN;
        endcase
    end

    assign o_msec    = msec_q;
    assign o_sec     = sec_q;
    assign o_min     = min_q;
    assign o_hour    = hour_q;
    assign o_pos_sel = pos_q;
    assign o_edit    = edit_q;

endmodule
